// File: rtl/mem_arb.sv
// Round-robin arbiter that gives NPORTS requesters access to a single memory port.
// Misaligned requests complete in one cycle with err set. Aligned requests take LATENCY access cycles and then a done cycle.
module mem_arb #(
  parameter int NPORTS  = 2,
  parameter int AW      = 16,
  parameter int LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NPORTS-1:0]    req,
  input  logic [NPORTS-1:0]    we,
  input  logic [2*NPORTS-1:0]  mode,
  input  logic [AW*NPORTS-1:0] addr,
  input  logic [32*NPORTS-1:0] wdata,
  output logic [NPORTS-1:0]    done,
  output logic                 err,
  output logic [31:0]          rdata,
  output logic                 mem_we,
  output logic [1:0]           mem_mode,
  output logic [AW-1:0]        mem_addr,
  output logic [31:0]          mem_wdata,
  input  logic [31:0]          mem_rdata
);

  localparam int IW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   gnt;
  logic [3:0]      cnt;
  logic            lat_we;

  logic [2*NPORTS-1:0] req2;
  logic [2*NPORTS-1:0] req_rot;
  logic                found;
  logic [IW-1:0]       gidx;
  logic                g_we;
  logic [1:0]          g_mode;
  logic [AW-1:0]       g_addr;
  logic [31:0]         g_wdata;
  logic                misaligned;

  // Rotate the request vector so that bit 0 is the port after the last grant.
  assign req2    = {req, req};
  assign req_rot = req2 >> (int'(ptr) + 1);

  always_comb begin
    found = 1'b0;
    gidx  = ptr;
    for (int i = 0; i < NPORTS; i++) begin
      if (!found && req_rot[i]) begin
        found = 1'b1;
        gidx  = IW'((int'(ptr) + 1 + i) % NPORTS);
      end
    end
  end

  always_comb begin
    g_we    = 1'b0;
    g_mode  = 2'b00;
    g_addr  = '0;
    g_wdata = '0;
    for (int i = 0; i < NPORTS; i++) begin
      if (gidx == IW'(i)) begin
        g_we    = we[i];
        g_mode  = (mode[2*i +: 2] == 2'b11) ? 2'b00 : mode[2*i +: 2];
        g_addr  = addr[AW*i +: AW];
        g_wdata = wdata[32*i +: 32];
      end
    end
  end

  assign misaligned = ((g_mode == 2'b00) && (g_addr[1:0] != 2'b00)) ||
                      ((g_mode == 2'b01) && g_addr[0]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= IW'(NPORTS - 1);
      gnt       <= '0;
      cnt       <= '0;
      lat_we    <= 1'b0;
      done      <= '0;
      err       <= 1'b0;
      rdata     <= '0;
      mem_we    <= 1'b0;
      mem_mode  <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      done   <= '0;
      err    <= 1'b0;
      mem_we <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            ptr <= gidx;
            gnt <= gidx;
            if (misaligned) begin
              state      <= RESP;
              done[gidx] <= 1'b1;
              err        <= 1'b1;
            end else begin
              state     <= ACCESS;
              cnt       <= 4'(LATENCY - 1);
              lat_we    <= g_we;
              mem_mode  <= g_mode;
              mem_addr  <= g_addr;
              mem_wdata <= g_wdata;
              // With a one-cycle access, the first access cycle is also the final one.
              mem_we    <= (LATENCY == 1) ? g_we : 1'b0;
            end
          end
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            if (!lat_we) rdata <= mem_rdata;
            state     <= RESP;
            done[gnt] <= 1'b1;
            mem_mode  <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
          end else begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) mem_we <= lat_we;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arb.sv
// Bench for mem_arb. It drives a table of single-port vectors, a held two-port round-robin sequence and a misaligned-pointer sequence.
// A LATENCY=3 instance is reset partway through a write.
module tb_mem_arb;

  localparam int NP   = 2;
  localparam int AW   = 16;
  localparam int LAT  = 2;
  localparam int LAT3 = 3;
  localparam logic [31:0] RD_BASE = 32'hDEBDBEFF;

  logic              clk = 1'b0;
  logic              reset;
  logic [NP-1:0]     req, req3, we;
  logic [2*NP-1:0]   mode;
  logic [AW*NP-1:0]  addr;
  logic [32*NP-1:0]  wdata;
  logic [31:0]       mem_rdata;

  logic [NP-1:0]     done, done3;
  logic              err, err3, mem_we, mem_we3;
  logic [31:0]       rdata, rdata3, mem_wdata, mem_wdata3;
  logic [1:0]        mem_mode, mem_mode3;
  logic [AW-1:0]     mem_addr, mem_addr3;

  // Memory model: the read value depends on the address, so a capture at the wrong time shows up.
  assign mem_rdata = RD_BASE ^ {mem_addr, mem_addr};

  mem_arb #(.NPORTS(NP), .AW(AW), .LATENCY(LAT)) u_dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .mode(mode), .addr(addr),
    .wdata(wdata), .done(done), .err(err), .rdata(rdata), .mem_we(mem_we),
    .mem_mode(mem_mode), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata));

  mem_arb #(.NPORTS(NP), .AW(AW), .LATENCY(LAT3)) u_dut3 (
    .clk(clk), .reset(reset), .req(req3), .we(we), .mode(mode), .addr(addr),
    .wdata(wdata), .done(done3), .err(err3), .rdata(rdata3), .mem_we(mem_we3),
    .mem_mode(mem_mode3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .mem_rdata(mem_rdata));

  always #5 clk = ~clk;

  typedef struct {
    int          port;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [1:0]    mode;
    logic [31:0]   wdata;
  } wr_t;

  typedef struct {
    int          port;
    logic        we;
    logic [1:0]  mode;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  exp_t sb[$];
  wr_t  wq[$];
  vec_t tbl[10];

  int cyc = 0;
  int n_checks = 0, n_fail = 0, n_done = 0, n_we3 = 0, n_done3 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_evt(input string name, input int act, input int exp);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Scoreboard for the main instance. Each done pulse and each write strobe pops one expectation.
  always @(negedge clk) begin
    exp_t e;
    wr_t  w;
    if (!reset) begin
      if (done != '0 || err) begin
        n_done++;
        if (sb.size() == 0) fail_evt("unexpected_done", int'(done), 0);
        else begin
          e = sb.pop_front();
          chk("done_port", 32'(done), 32'(1 << e.port));
          chk("err", 32'(err), 32'(e.err));
          chk("rdata", rdata, e.rdata);
          chk("latency", 32'(cyc), 32'(e.cyc));
          chk("idle_mem_addr", 32'(mem_addr), 32'h0);
        end
      end
      if (mem_we) begin
        if (wq.size() == 0) fail_evt("unexpected_mem_we", 1, 0);
        else begin
          w = wq.pop_front();
          chk("wr_addr", 32'(mem_addr), 32'(w.addr));
          chk("wr_mode", 32'(mem_mode), 32'(w.mode));
          chk("wr_data", mem_wdata, w.wdata);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (mem_we3) n_we3++;
    if (done3 != '0) n_done3++;
  end

  task automatic wait_dones(input int target);
    int b;
    b = 0;
    while (n_done < target && b < 60) begin
      @(negedge clk); #1;
      b++;
    end
    if (n_done < target) fail_evt("done_timeout", n_done, target);
  endtask

  task automatic set_port(input int p, input logic w, input logic [1:0] m,
                          input logic [15:0] a, input logic [31:0] d);
    we[p]            = w;
    mode[2*p +: 2]   = m;
    addr[AW*p +: AW] = a;
    wdata[32*p +: 32] = d;
  endtask

  task automatic run_vec(input vec_t v);
    int start;
    @(posedge clk); #1;
    we    = NP'($urandom);
    mode  = (2*NP)'($urandom);
    addr  = (AW*NP)'($urandom);
    wdata = {$urandom, $urandom};
    set_port(v.port, v.we, v.mode, v.addr, v.wdata);
    start = n_done;
    sb.push_back('{v.port, v.exp_rdata, v.exp_err, cyc + (v.exp_err ? 1 : LAT + 1)});
    if (!v.exp_err && v.we) wq.push_back('{v.addr, v.mode, v.wdata});
    req = NP'(1 << v.port);
    // After the grant edge, disturb the granted port. The transfer must use the values latched at grant.
    @(posedge clk); #2;
    set_port(v.port, ~v.we, ~v.mode, ~v.addr, ~v.wdata);
    wait_dones(start + 1);
    req = '0;
  endtask

  initial begin
    int c, start, w0, d0, b;
    reset = 1'b1;
    req = '0; req3 = '0; we = '0; mode = '0; addr = '0; wdata = '0;

    tbl[0] = '{0, 1'b0, 2'b00, 16'h0010, 32'h0,        1'b0, 32'hDEADBEEF};
    tbl[1] = '{0, 1'b1, 2'b01, 16'h0006, 32'h0000ABCD, 1'b0, 32'hDEADBEEF};
    tbl[2] = '{1, 1'b0, 2'b00, 16'h0002, 32'h0,        1'b1, 32'hDEADBEEF};
    tbl[3] = '{1, 1'b0, 2'b01, 16'h0022, 32'h0,        1'b0, 32'hDE9FBEDD};
    tbl[4] = '{0, 1'b0, 2'b10, 16'h0013, 32'h0,        1'b0, 32'hDEAEBEEC};
    tbl[5] = '{0, 1'b1, 2'b01, 16'h0007, 32'h11112222, 1'b1, 32'hDEAEBEEC};
    tbl[6] = '{1, 1'b1, 2'b00, 16'h0100, 32'h12345678, 1'b0, 32'hDEAEBEEC};
    tbl[7] = '{1, 1'b0, 2'b11, 16'h0003, 32'h0,        1'b1, 32'hDEAEBEEC};
    tbl[8] = '{0, 1'b0, 2'b11, 16'h0040, 32'h0,        1'b0, 32'hDEFDBEBF};
    tbl[9] = '{1, 1'b1, 2'b10, 16'h0005, 32'h000000EE, 1'b0, 32'hDEFDBEBF};

    @(negedge clk); @(negedge clk);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_mode", 32'(mem_mode), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    @(posedge clk); #1 reset = 1'b0;

    for (int i = 0; i < 10; i++) run_vec(tbl[i]);

    // Held requests on both ports after reset should be granted 0,1,0,1.
    reset = 1'b1;
    @(posedge clk); @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;
    set_port(0, 1'b0, 2'b00, 16'h0010, 32'h0);
    set_port(1, 1'b1, 2'b00, 16'h0200, 32'hA0A0A0A0);
    c = cyc;
    start = n_done;
    for (int k = 0; k < 4; k++) begin
      sb.push_back('{k % 2, 32'hDEADBEEF, 1'b0, c + LAT + 1 + k * (LAT + 2)});
      if (k % 2 == 1) wq.push_back('{16'h0200, 2'b00, 32'hA0A0A0A0});
    end
    req = 2'b11;
    wait_dones(start + 4);
    req = '0;

    // A misaligned grant to port 0 still moves the pointer, so port 1 wins the next contest.
    run_vec('{0, 1'b0, 2'b01, 16'h0001, 32'h0, 1'b1, 32'hDEADBEEF});
    @(posedge clk); #1;
    set_port(0, 1'b0, 2'b00, 16'h0010, 32'h0);
    set_port(1, 1'b0, 2'b00, 16'h0030, 32'h0);
    start = n_done;
    sb.push_back('{1, 32'hDE8DBECF, 1'b0, cyc + LAT + 1});
    req = 2'b11;
    wait_dones(start + 1);
    req = '0;

    // Reset the LATENCY=3 instance in the second access cycle of a write.
    @(posedge clk); #1;
    set_port(0, 1'b1, 2'b00, 16'h0020, 32'hCAFEF00D);
    set_port(1, 1'b1, 2'b00, 16'h0024, 32'h55AA55AA);
    w0 = n_we3;
    d0 = n_done3;
    req3 = 2'b01;
    @(posedge clk); #2;
    chk("acc3_addr", 32'(mem_addr3), 32'h0020);
    chk("acc3_we_early", 32'(mem_we3), 32'h0);
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    chk("rst3_mem_addr", 32'(mem_addr3), 32'h0);
    chk("rst3_mem_wdata", mem_wdata3, 32'h0);
    chk("rst3_mem_we", 32'(mem_we3), 32'h0);
    req3 = 2'b11;
    @(posedge clk); @(posedge clk); #2;
    chk("rst3_we_count", 32'(n_we3 - w0), 32'h0);
    chk("rst3_done_count", 32'(n_done3 - d0), 32'h0);
    reset = 1'b0;
    b = 0;
    while (n_done3 == d0 && b < 60) begin
      @(negedge clk); #1;
      b++;
    end
    if (n_done3 == d0) fail_evt("done3_timeout", n_done3, d0 + 1);
    else chk("rst3_first_grant", 32'(done3), 32'h1);
    req3 = '0;

    repeat (4) @(posedge clk);
    #1;
    chk("sb_empty", 32'(sb.size()), 32'h0);
    chk("wq_empty", 32'(wq.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 SHALL take parameter NPORTS, default 2: number of requester ports, legal range 2..8.
REQ-002 SHALL take parameter AW, default 16: address width.
REQ-003 SHALL take parameter LATENCY, default 2: memory access cycles per transfer, legal range 1..15.
REQ-004 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-high reset.
REQ-006 Port req, input, NPORTS: per-port access request, level; bit i belongs to port i.
REQ-007 Port we, input, NPORTS: per-port write enable (1 = write, 0 = read).
REQ-008 Port mode, input, 2*NPORTS: per-port size; 00 word, 01 half, 10 byte, 11 treated as word; bits [2i+1:2i] belong to port i.
REQ-009 Port addr, input, AW*NPORTS: per-port byte address.
REQ-010 Port wdata, input, 32*NPORTS: per-port write data.
REQ-011 Port done, output, NPORTS: one-cycle completion pulse to the granted port.
REQ-012 Port err, output, 1: one-cycle pulse, coincident with done, on a misaligned request.
REQ-013 Port rdata, output, 32: read data of the last completed read.
REQ-014 Port mem_we, output, 1: memory write strobe.
REQ-015 Port mem_mode, output, 2: memory access size.
REQ-016 Port mem_addr, output, AW: memory address.
REQ-017 Port mem_wdata, output, 32: memory write data.
REQ-018 Port mem_rdata, input, 32: memory read data, valid combinationally while mem_addr/mem_mode are stable.

Function
REQ-019 SHALL implement FSM states IDLE, ACCESS and RESP.
REQ-020 IDLE: if any req bit is set, SHALL grant one port by round-robin, starting at the port after the last granted port, modulo NPORTS.
REQ-021 On grant, SHALL latch the granted port's index, we, mode, addr and wdata; later changes on that port are ignored until done.
REQ-022 Alignment: a half access with addr[0]=1, or a word access with addr[1:0]!=00, is misaligned.
REQ-023 A misaligned grant SHALL go IDLE -> RESP with err=1, drive no memory strobe, and leave rdata unchanged.
REQ-024 An aligned grant SHALL go IDLE -> ACCESS and load a down-counter with LATENCY-1.
REQ-025 ACCESS: mem_addr, mem_mode and mem_wdata SHALL be driven from the latched values; the counter SHALL decrement each cycle.
REQ-026 ACCESS, final cycle (counter = 0): mem_we SHALL equal the latched we; mem_we SHALL be 0 in every other cycle, so each write is exactly one strobe.
REQ-027 ACCESS, final cycle of a read: rdata SHALL capture mem_rdata at the clock edge; then ACCESS -> RESP.
REQ-028 RESP: done[g] SHALL be 1 for one cycle, g = granted port; no arbitration occurs in RESP; then RESP -> IDLE.
REQ-029 Latency: a req sampled in IDLE at cycle t SHALL produce done at t+LATENCY+1 (aligned) or at t+1 (misaligned).
REQ-030 The round-robin pointer SHALL update to the granted index at grant time, including misaligned grants.
REQ-031 A requester still holding req in the IDLE cycle after done SHALL be treated as a new request.
REQ-032 Outside ACCESS, mem_addr, mem_mode and mem_wdata SHALL be 0; mem_we SHALL be 0.
REQ-033 rdata SHALL hold its value across writes, errors and idle cycles.

Reset
REQ-034 While reset=1, state SHALL be IDLE and the round-robin pointer SHALL be NPORTS-1, so port 0 has first priority.
REQ-035 While reset=1, done, err, mem_we, mem_mode, mem_addr, mem_wdata and rdata SHALL be 0.
REQ-036 Reset asserted mid-ACCESS SHALL drop mem_we immediately, abandon the transfer, and issue no done.

Verification
REQ-037 LATENCY=2, port0 read word 0x0010, mem_rdata=0xDEADBEEF -> done[0] 3 cycles after the req sample, rdata=0xDEADBEEF, mem_we never 1.
REQ-038 Port0 write half 0x0006 data 0x0000ABCD -> exactly one mem_we cycle with mem_addr=0x0006, mem_mode=01, mem_wdata=0x0000ABCD.
REQ-039 req=2'b11 held continuously, NPORTS=2 -> grants alternate 0,1,0,1; the done pulses alternate accordingly.
REQ-040 Port1 word read at 0x0002 -> done[1] and err together 1 cycle after the req sample; no memory access; rdata unchanged.
REQ-041 reset pulsed during the second ACCESS cycle of a write with LATENCY=3 -> mem_we never 1, no done; after release, port0 is granted first.
